// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Decode-side immediate generator for RV64 instructions. Each accepted
// instruction is classified into an immediate format, its 64-bit immediate
// is built, and the result is queued in a small result FIFO until execute
// consumes it. A flush empties the FIFO and drops any same-cycle push.
//
// Optional feature macro: IMM_DEC_ZICSR_EN
//   defined     : SYSTEM with funct3[2]=1 decodes as ZIMM, imm = zext(rs1 field)
//   not defined : SYSTEM with funct3[2]=1 decodes as NONE, imm = 0, illegal = 1
module imm_decode_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_fmt,
   output logic [63:0] out_imm,
   output logic        out_illegal
);

   localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CntW = PtrW + 1;

   typedef enum logic [2:0] {
      FmtNone  = 3'd0,
      FmtI     = 3'd1,
      FmtS     = 3'd2,
      FmtB     = 3'd3,
      FmtU     = 3'd4,
      FmtJ     = 3'd5,
      FmtShamt = 3'd6,
      FmtZimm  = 3'd7
   } fmt_e;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] immI;
   logic [63:0] immS;
   logic [63:0] immB;
   logic [63:0] immU;
   logic [63:0] immJ;

   fmt_e        decFmt;
   logic [63:0] decImm;
   logic        decIllegal;

   fmt_e        fmtMem_q     [DEPTH];
   logic [63:0] immMem_q     [DEPTH];
   logic        illegalMem_q [DEPTH];

   logic [PtrW-1:0] wrPtr_q, wrPtr_d;
   logic [PtrW-1:0] rdPtr_q, rdPtr_d;
   logic [CntW-1:0] count_q, count_d;

   logic push;
   logic pop;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   assign immI = {{52{in_instr[31]}}, in_instr[31:20]};
   assign immS = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign immB = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
   assign immU = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
   assign immJ = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

   // Classify the incoming word and select its immediate; anything not
   // recognised (including compressed encodings) is flagged illegal.
   always_comb begin
      decFmt     = FmtNone;
      decImm     = '0;
      decIllegal = 1'b0;
      if (in_instr[1:0] != 2'b11) begin
         decIllegal = 1'b1;
      end else begin
         case (opcode)
            7'b0010011: begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  decFmt = FmtShamt;
                  decImm = {58'b0, in_instr[25:20]};
               end else begin
                  decFmt = FmtI;
                  decImm = immI;
               end
            end
            7'b0011011: begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  decFmt = FmtShamt;
                  decImm = {59'b0, in_instr[24:20]};
               end else begin
                  decFmt = FmtI;
                  decImm = immI;
               end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
               decFmt = FmtI;
               decImm = immI;
            end
            7'b0100011: begin
               decFmt = FmtS;
               decImm = immS;
            end
            7'b1100011: begin
               decFmt = FmtB;
               decImm = immB;
            end
            7'b0110111, 7'b0010111: begin
               decFmt = FmtU;
               decImm = immU;
            end
            7'b1101111: begin
               decFmt = FmtJ;
               decImm = immJ;
            end
            7'b1110011: begin
               if (funct3[2]) begin
`ifdef IMM_DEC_ZICSR_EN
                  decFmt = FmtZimm;
                  decImm = {59'b0, in_instr[19:15]};
`else
                  decIllegal = 1'b1;
`endif
               end else if (funct3 != 3'b000) begin
                  decFmt = FmtI;
                  decImm = immI;
               end
            end
            7'b0110011, 7'b0111011: begin
               decFmt = FmtNone;
            end
            default: begin
               decIllegal = 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = (count_q != CntW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // Pointer and occupancy bookkeeping; flush wins over any push or pop.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + PtrW'(1);
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CntW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
         end
      end
   end

   // Control state register; reset outranks flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Result storage; contents only matter while the occupancy says so.
   always_ff @(posedge clk) begin
      if (push) begin
         fmtMem_q[wrPtr_q]     <= decFmt;
         immMem_q[wrPtr_q]     <= decImm;
         illegalMem_q[wrPtr_q] <= decIllegal;
      end
   end

   assign out_fmt     = out_valid ? fmtMem_q[rdPtr_q]     : FmtNone;
   assign out_imm     = out_valid ? immMem_q[rdPtr_q]     : 64'd0;
   assign out_illegal = out_valid ? illegalMem_q[rdPtr_q] : 1'b0;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// Drives directed and randomized traffic into imm_decode_stage and compares
// every cycle against a queue-based model of the decode FIFO.
// Honours IMM_DEC_ZICSR_EN the same way the design does.
module tb_imm_decode_stage;

   localparam int DEPTH = 2;

   typedef struct {
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        ill;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_fmt;
   logic [63:0] out_imm;
   logic        out_illegal;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   entry_t modelQ[$];

   imm_decode_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_fmt    (out_fmt),
      .out_imm    (out_imm),
      .out_illegal(out_illegal)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference decode built from field arithmetic on a sign-extended word.
   function automatic entry_t modelDecode(input logic [31:0] w);
      entry_t e;
      longint s;
      logic [6:0] op;
      logic [2:0] f3;
      s  = longint'($signed(w));
      op = w[6:0];
      f3 = w[14:12];
      e.fmt = 3'd0;
      e.imm = 64'd0;
      e.ill = 1'b0;
      if (w[1:0] != 2'b11) begin
         e.ill = 1'b1;
      end else if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
         e.fmt = 3'd6;
         e.imm = (op == 7'h13) ? 64'(w[25:20]) : 64'(w[24:20]);
      end else if (op == 7'h13 || op == 7'h1B || op == 7'h03 || op == 7'h67 || op == 7'h0F ||
                   (op == 7'h73 && f3 >= 3'd1 && f3 <= 3'd3)) begin
         e.fmt = 3'd1;
         e.imm = 64'(s >>> 20);
      end else if (op == 7'h23) begin
         e.fmt = 3'd2;
         e.imm = 64'(((s >>> 25) <<< 5) | longint'(w[11:7]));
      end else if (op == 7'h63) begin
         e.fmt = 3'd3;
         e.imm = 64'(((s >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                     (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1));
      end else if (op == 7'h37 || op == 7'h17) begin
         e.fmt = 3'd4;
         e.imm = 64'((s >>> 12) <<< 12);
      end else if (op == 7'h6F) begin
         e.fmt = 3'd5;
         e.imm = 64'(((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                     (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1));
      end else if (op == 7'h73 && f3 >= 3'd4) begin
`ifdef IMM_DEC_ZICSR_EN
         e.fmt = 3'd7;
         e.imm = 64'(w[19:15]);
`else
         e.ill = 1'b1;
`endif
      end else if (op == 7'h73 || op == 7'h33 || op == 7'h3B) begin
         e.fmt = 3'd0;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Advance the model at each edge using the inputs the DUT also samples.
   always @(posedge clk) begin
      int sz;
      bit doPush;
      bit doPop;
      sz = modelQ.size();
      if (reset || flush) begin
         modelQ.delete();
      end else begin
         doPush = in_valid && (sz != DEPTH);
         doPop  = out_ready && (sz != 0);
         if (doPop) void'(modelQ.pop_front());
         if (doPush) modelQ.push_back(modelDecode(in_instr));
      end
   end

   // Compare every DUT output against the model on the falling edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("out_valid", 64'(out_valid), 64'(modelQ.size() != 0));
         checkOutput("in_ready", 64'(in_ready), 64'(modelQ.size() != DEPTH));
         if (modelQ.size() != 0) begin
            checkOutput("out_fmt", 64'(out_fmt), 64'(modelQ[0].fmt));
            checkOutput("out_imm", out_imm, modelQ[0].imm);
            checkOutput("out_illegal", 64'(out_illegal), 64'(modelQ[0].ill));
         end else begin
            checkOutput("empty_fmt", 64'(out_fmt), 64'd0);
            checkOutput("empty_imm", out_imm, 64'd0);
            checkOutput("empty_illegal", 64'(out_illegal), 64'd0);
         end
      end
   end

   // Drive one cycle of inputs and settle just after the next rising edge.
   task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit rdy,
                                input bit fl, input bit rst);
      in_valid  = v;
      in_instr  = instr;
      out_ready = rdy;
      flush     = fl;
      reset     = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic pinModel(input string name, input logic [31:0] w, input logic [2:0] fmt,
                           input logic [63:0] imm, input bit ill);
      entry_t e;
      e = modelDecode(w);
      checkOutput({name, "_fmt"}, 64'(e.fmt), 64'(fmt));
      checkOutput({name, "_imm"}, e.imm, imm);
      checkOutput({name, "_ill"}, 64'(e.ill), 64'(ill));
   endtask

   logic [6:0] opPool [12] = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h0F, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

   initial begin
      logic [31:0] w;
      // Literal anchors for the reference decode.
      pinModel("m_addi", 32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      pinModel("m_lui",  32'h123450B7, 3'd4, 64'h0000_0000_1234_5000, 1'b0);
      pinModel("m_beq",  32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      pinModel("m_jal",  32'h0080006F, 3'd5, 64'h8, 1'b0);
      pinModel("m_slli", 32'h03F09093, 3'd6, 64'd63, 1'b0);
`ifdef IMM_DEC_ZICSR_EN
      pinModel("m_csrrwi", 32'h3002D073, 3'd7, 64'd5, 1'b0);
`else
      pinModel("m_csrrwi", 32'h3002D073, 3'd0, 64'd0, 1'b1);
`endif
      pinModel("m_zero", 32'h00000000, 3'd0, 64'd0, 1'b1);

      applyStimulus(0, 32'h0, 0, 0, 1);
      applyStimulus(0, 32'h0, 0, 0, 1);
      checkEn = 1'b1;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

      // Single addi, visible one edge later.
      applyStimulus(1, 32'hFFF00093, 0, 0, 0);
      checkOutput("addi_valid", 64'(out_valid), 64'd1);
      checkOutput("addi_fmt", 64'(out_fmt), 64'd1);
      checkOutput("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);

      // Back-to-back stream with consumer always ready.
      applyStimulus(1, 32'h123450B7, 1, 0, 0);
      checkOutput("lui_imm", out_imm, 64'h12345000);
      applyStimulus(1, 32'hFE000EE3, 1, 0, 0);
      checkOutput("beq_fmt", 64'(out_fmt), 64'd3);
      applyStimulus(1, 32'h0080006F, 1, 0, 0);
      checkOutput("jal_imm", out_imm, 64'h8);
      applyStimulus(1, 32'h03F09093, 1, 0, 0);
      applyStimulus(1, 32'h3002D073, 1, 0, 0);
      applyStimulus(1, 32'h00000000, 1, 0, 0);
      checkOutput("zero_illegal", 64'(out_illegal), 64'd1);
      applyStimulus(0, 32'h0, 1, 0, 0);

      // Backpressure: third instruction waits until a slot frees.
      applyStimulus(1, 32'h00100093, 0, 0, 0);
      applyStimulus(1, 32'h00200093, 0, 0, 0);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1, 32'h00300093, 0, 0, 0);
      checkOutput("held_head_imm", out_imm, 64'd1);
      applyStimulus(1, 32'h00300093, 1, 0, 0);
      applyStimulus(1, 32'h00300093, 0, 0, 0);
      checkOutput("third_taken_full", 64'(in_ready), 64'd0);

      // Flush a full FIFO while offering another instruction.
      applyStimulus(1, 32'h00400093, 0, 1, 0);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of traffic.
      applyStimulus(1, 32'h00500093, 0, 0, 0);
      applyStimulus(1, 32'h00600093, 0, 0, 1);
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         w = $urandom;
         if ($urandom_range(7) != 0) w[6:0] = opPool[$urandom_range(11)];
         applyStimulus($urandom_range(3) != 0, w, $urandom_range(2) != 0,
                       $urandom_range(31) == 0, $urandom_range(127) == 0);
      end

      applyStimulus(0, 32'h0, 0, 0, 0);
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
